// File: rtl/minall_seq.sv
// ---------------------------------------------------------------------------
// minall_seq
//   Multi-cycle reduction sequencer. It sweeps a block of data-memory words,
//   one read per cycle, and folds them into a 16-bit accumulator through the
//   external ALU. It supports ADD, XOR, MIN and MINALL. MIN and MINALL behave
//   the same way. The final value is reported with a one-cycle done pulse.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high
//   start      : request, sampled only while idle
//   op         : reduction opcode (0010 ADD, 0011 XOR, 0100 MIN, 0111 MINALL)
//   base_addr  : address of the first word
//   count      : number of words, 0 .. 2^ADDR_W
//   mem_rd_en  : data-memory read strobe
//   mem_addr   : data-memory read address (wraps modulo 2^ADDR_W)
//   mem_rdata  : read data, valid one cycle after mem_rd_en
//   alu_ins    : registered ALU opcode
//   alu_a      : running accumulator presented to the ALU
//   alu_b      : memory word presented to the ALU
//   alu_out    : combinational ALU result
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle completion pulse
//   err        : pulses with done when the opcode was unsupported
//   result     : final value, held until the next accepted start
// ---------------------------------------------------------------------------
module minall_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        alu_ins,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       result
);

  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_MIN    = 4'b0100;
  localparam logic [3:0] OP_MINALL = 4'b0111;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       acc;
  logic [ADDR_W:0]   remaining;
  logic              rd_valid;
  logic              op_legal;
  logic [15:0]       op_identity;

  // Decode the requested opcode into legality and the fold identity. MIN
  // starts from all-ones so that the first word always wins.
  always_comb begin
    op_legal    = 1'b0;
    op_identity = 16'h0000;
    case (op)
      OP_ADD, OP_XOR: begin
        op_legal    = 1'b1;
        op_identity = 16'h0000;
      end
      OP_MIN, OP_MINALL: begin
        op_legal    = 1'b1;
        op_identity = 16'hFFFF;
      end
      default: begin
        op_legal    = 1'b0;
        op_identity = 16'h0000;
      end
    endcase
  end

  assign alu_a = acc;
  assign alu_b = mem_rdata;
  assign busy  = (state != S_IDLE);

  // Sequencer. The remaining counter holds how many more reads must be issued
  // after the one currently on the bus, so RUN leaves when it reaches zero.
  // rd_valid trails mem_rd_en by one cycle, which marks the cycles where
  // mem_rdata carries a word to fold into the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      alu_ins   <= 4'b0000;
      acc       <= 16'h0000;
      remaining <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= 16'h0000;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= mem_rd_en;

      if (rd_valid) begin
        acc <= alu_out;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            if (op_legal) begin
              alu_ins <= op;
              acc     <= op_identity;
              if (count == '0) begin
                result <= op_identity;
                done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                mem_rd_en <= 1'b1;
                mem_addr  <= base_addr;
                remaining <= count - CNT_ONE;
                state     <= S_RUN;
              end
            end else begin
              // Unsupported opcode: report without touching acc, result or
              // alu_ins, so the ALU never sees an illegal opcode.
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end

        S_RUN: begin
          if (remaining != '0) begin
            remaining <= remaining - CNT_ONE;
            mem_addr  <= mem_addr + ADDR_ONE;
          end else begin
            mem_rd_en <= 1'b0;
            state     <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // The last word is on mem_rdata now; acc takes it through rd_valid.
          result <= alu_out;
          done   <= 1'b1;
          state  <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_minall_seq.sv
// ---------------------------------------------------------------------------
// tb_minall_seq
//   Self-checking bench for minall_seq. It models the data memory (one-cycle
//   read latency) and the ALU around the sequencer. Each reduction result is
//   predicted from the memory contents with plain loop arithmetic.
// ---------------------------------------------------------------------------
module tb_minall_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_ins;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] result;

  logic [15:0] mem [256];

  int tests_run;
  int tests_failed;

  minall_seq #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .base_addr (base_addr),
    .count     (count),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .alu_ins   (alu_ins),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // ALU that sits next to the sequencer.
  always_comb begin
    alu_out = 16'h0000;
    case (alu_ins)
      4'b0010: alu_out = alu_a + alu_b;
      4'b0011: alu_out = alu_a ^ alu_b;
      4'b0100, 4'b0111: alu_out = (alu_a < alu_b) ? alu_a : alu_b;
      default: alu_out = 16'h0000;
    endcase
  end

  function automatic bit is_legal(input logic [3:0] o);
    return (o == 4'b0010) || (o == 4'b0011) || (o == 4'b0100) || (o == 4'b0111);
  endfunction

  // Reference reduction computed directly from the memory image.
  function automatic logic [15:0] ref_reduce(input logic [3:0] o, input logic [7:0] b, input int n);
    logic [15:0] a;
    logic [15:0] w;
    a = ((o == 4'b0100) || (o == 4'b0111)) ? 16'hFFFF : 16'h0000;
    for (int i = 0; i < n; i++) begin
      w = mem[(int'(b) + i) % 256];
      if (o == 4'b0010) a = a + w;
      else if (o == 4'b0011) a = a ^ w;
      else a = (w < a) ? w : a;
    end
    return a;
  endfunction

  // Issues one request and observes cycles 1.. after acceptance. Optionally
  // pokes a competing start at cycle poke_cycle. Reads must form a gap-free
  // burst from cycle 1 at base, base+1, ... for seq_ok to stay set.
  task automatic run_txn(input logic [3:0] t_op, input logic [7:0] t_base, input logic [8:0] t_count,
                         input int poke_cycle, output int done_cyc, output logic err_seen,
                         output logic [15:0] res, output int nreads, output logic seq_ok);
    int k;
    logic [7:0] exp_addr;
    done_cyc = -1;
    err_seen = 1'b0;
    res      = 16'h0000;
    nreads   = 0;
    seq_ok   = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = t_op; base_addr = t_base; count = t_count;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    while (k <= 400) begin
      if (poke_cycle != 0 && k == poke_cycle) begin
        start = 1'b1; op = 4'b0010; base_addr = t_base + 8'h40; count = 9'd1;
      end else begin
        start = 1'b0;
      end
      if (mem_rd_en) begin
        exp_addr = t_base + 8'(nreads);
        if (mem_addr !== exp_addr) seq_ok = 1'b0;
        if (k != nreads + 1) seq_ok = 1'b0;
        nreads++;
      end
      if (done) begin
        done_cyc = k;
        err_seen = err;
        res      = result;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'b0000; base_addr = 8'h00; count = 9'd0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_en: got %b expected 0", mem_rd_en); end
    tests_run++; if (mem_addr !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h expected 00", mem_addr); end
    tests_run++; if (alu_ins !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_alu_ins: got %b expected 0000", alu_ins); end
    tests_run++; if (alu_a !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_acc: got %h expected 0000", alu_a); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done_err: got %b%b expected 00", done, err); end
    tests_run++; if (result !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 0000", result); end
    reset = 1'b0;
  endtask

  task automatic test_minall();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    mem[8'h10] = 16'h0042; mem[8'h11] = 16'h0007; mem[8'h12] = 16'h1234; mem[8'h13] = 16'h0009;
    run_txn(4'b0111, 8'h10, 9'd4, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'h0007) begin tests_failed++; $display("[TB] FAIL minall_result: got %h expected 0007", r); end
    tests_run++; if (dc != 6) begin tests_failed++; $display("[TB] FAIL minall_done_cycle: got %0d expected 6", dc); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("[TB] FAIL minall_err: got %b expected 0", e); end
    tests_run++; if (nr != 4 || ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL minall_reads: got %0d reads seq_ok=%b expected 4 reads seq_ok=1", nr, ok); end
  endtask

  task automatic test_add_wrap();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    mem[8'hFE] = 16'hFFFF; mem[8'hFF] = 16'h0002; mem[8'h00] = 16'h0003;
    run_txn(4'b0010, 8'hFE, 9'd3, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'h0004) begin tests_failed++; $display("[TB] FAIL add_wrap_result: got %h expected 0004", r); end
    tests_run++; if (dc != 5) begin tests_failed++; $display("[TB] FAIL add_wrap_done_cycle: got %0d expected 5", dc); end
    tests_run++; if (nr != 3 || ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_wrap_reads: got %0d reads seq_ok=%b expected 3 reads seq_ok=1", nr, ok); end
  endtask

  task automatic test_count_zero();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    run_txn(4'b0011, 8'h33, 9'd0, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'h0000) begin tests_failed++; $display("[TB] FAIL xor_zero_result: got %h expected 0000", r); end
    tests_run++; if (dc != 1 || nr != 0) begin tests_failed++; $display("[TB] FAIL xor_zero_timing: got done %0d reads %0d expected done 1 reads 0", dc, nr); end
    run_txn(4'b0100, 8'h33, 9'd0, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL min_zero_result: got %h expected ffff", r); end
    tests_run++; if (dc != 1 || nr != 0 || e !== 1'b0) begin tests_failed++; $display("[TB] FAIL min_zero_timing: got done %0d reads %0d err %b expected 1 0 0", dc, nr, e); end
  endtask

  task automatic test_illegal_op();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    mem[8'h50] = 16'h1111; mem[8'h51] = 16'h2222;
    run_txn(4'b0010, 8'h50, 9'd2, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'h3333) begin tests_failed++; $display("[TB] FAIL pre_illegal_result: got %h expected 3333", r); end
    run_txn(4'b0101, 8'h50, 9'd2, 0, dc, e, r, nr, ok);
    tests_run++; if (e !== 1'b1 || dc != 1) begin tests_failed++; $display("[TB] FAIL illegal_err: got err %b done %0d expected err 1 done 1", e, dc); end
    tests_run++; if (nr != 0) begin tests_failed++; $display("[TB] FAIL illegal_reads: got %0d expected 0", nr); end
    tests_run++; if (r !== 16'h3333) begin tests_failed++; $display("[TB] FAIL illegal_result_held: got %h expected 3333", r); end
    tests_run++; if (alu_ins !== 4'b0010) begin tests_failed++; $display("[TB] FAIL illegal_alu_ins_held: got %b expected 0010", alu_ins); end
  endtask

  task automatic test_start_while_busy();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    mem[8'h10] = 16'h0042; mem[8'h11] = 16'h0007; mem[8'h12] = 16'h1234; mem[8'h13] = 16'h0009;
    mem[8'h50] = 16'h0001;
    run_txn(4'b0111, 8'h10, 9'd4, 2, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'h0007) begin tests_failed++; $display("[TB] FAIL busy_start_result: got %h expected 0007", r); end
    tests_run++; if (dc != 6 || nr != 4 || ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_start_timing: got done %0d reads %0d seq_ok %b expected 6 4 1", dc, nr, ok); end
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_start_no_queue: got busy %b rd_en %b expected 0 0", busy, mem_rd_en); end
  endtask

  task automatic test_full_sweep();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF - 16'(i);
    run_txn(4'b0100, 8'h00, 9'd256, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== 16'hFF00) begin tests_failed++; $display("[TB] FAIL sweep_result: got %h expected ff00", r); end
    tests_run++; if (dc != 258) begin tests_failed++; $display("[TB] FAIL sweep_done_cycle: got %0d expected 258", dc); end
    tests_run++; if (nr != 256 || ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL sweep_reads: got %0d seq_ok %b expected 256 1", nr, ok); end
  endtask

  task automatic test_reset_mid_run();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    logic done_seen;
    logic [15:0] exp_r;
    for (int i = 0; i < 8; i++) mem[8'h20 + i] = 16'($urandom);
    @(posedge clk); #1;
    start = 1'b1; op = 4'b0111; base_addr = 8'h20; count = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_idle: got busy %b rd_en %b expected 0 0", busy, mem_rd_en); end
    tests_run++; if (result !== 16'h0000) begin tests_failed++; $display("[TB] FAIL midreset_result: got %h expected 0000", result); end
    tests_run++; if (alu_ins !== 4'b0000 || alu_a !== 16'h0000) begin tests_failed++; $display("[TB] FAIL midreset_regs: got ins %b acc %h expected 0000 0000", alu_ins, alu_a); end
    done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++; if (done_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_no_done: got activity %b expected 0", done_seen); end
    exp_r = ref_reduce(4'b0111, 8'h20, 8);
    run_txn(4'b0111, 8'h20, 9'd8, 0, dc, e, r, nr, ok);
    tests_run++; if (r !== exp_r || dc != 10) begin tests_failed++; $display("[TB] FAIL midreset_restart: got %h done %0d expected %h done 10", r, dc, exp_r); end
  endtask

  task automatic test_random();
    int dc; logic e; logic [15:0] r; int nr; logic ok;
    logic [3:0] t_op;
    logic [7:0] t_base;
    int n;
    logic [15:0] exp_r;
    int exp_dc;
    logic [3:0] legal_ops [4];
    legal_ops[0] = 4'b0010; legal_ops[1] = 4'b0011; legal_ops[2] = 4'b0100; legal_ops[3] = 4'b0111;
    exp_r = result;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 9) < 7) t_op = legal_ops[$urandom_range(0, 3)];
      else t_op = 4'($urandom_range(0, 15));
      t_base = 8'($urandom_range(0, 255));
      n = (it == 5) ? 256 : $urandom_range(0, 20);
      if (is_legal(t_op)) begin
        exp_r  = ref_reduce(t_op, t_base, n);
        exp_dc = (n == 0) ? 1 : n + 2;
      end else begin
        exp_dc = 1;
      end
      run_txn(t_op, t_base, 9'(n), 0, dc, e, r, nr, ok);
      tests_run++; if (r !== exp_r) begin tests_failed++; $display("[TB] FAIL rand_result it=%0d op=%b n=%0d: got %h expected %h", it, t_op, n, r, exp_r); end
      tests_run++; if (dc != exp_dc) begin tests_failed++; $display("[TB] FAIL rand_done_cycle it=%0d: got %0d expected %0d", it, dc, exp_dc); end
      tests_run++; if (e !== !is_legal(t_op)) begin tests_failed++; $display("[TB] FAIL rand_err it=%0d: got %b expected %b", it, e, !is_legal(t_op)); end
      tests_run++; if (nr != (is_legal(t_op) ? n : 0) || ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_reads it=%0d: got %0d seq_ok %b expected %0d 1", it, nr, ok, is_legal(t_op) ? n : 0); end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1; start = 1'b0; op = 4'b0000; base_addr = 8'h00; count = 9'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_minall();
    test_add_wrap();
    test_count_zero();
    test_illegal_op();
    test_start_while_busy();
    test_full_sweep();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
